// File: rtl/counter_checker_pkg.sv
// rtl/counter_checker_pkg.sv - shared mode constants, width and checker FSM encoding
package counter_pkg;

   localparam int WIDTH = 4;

   localparam logic [1:0] MODE_UP  = 2'b00;
   localparam logic [1:0] MODE_DN  = 2'b01;
   localparam logic [1:0] MODE_DN3 = 2'b10;
   localparam logic [1:0] MODE_LD  = 2'b11;

   typedef enum logic [1:0] {
      SYNC  = 2'b00,
      CHECK = 2'b01,
      FAIL  = 2'b10
   } chk_state_t;

endpackage

// File: rtl/counter_checker_if.sv
// rtl/counter_checker_if.sv - counter stimulus and response bundle observed by the checker
interface counter_if #(
   parameter int WIDTH = 4
);
   logic             enable;
   logic [WIDTH-1:0] D;
   logic [1:0]       mode;
   logic [WIDTH-1:0] Q;
   logic             rco;
   logic             load;

   // the bench side drives both the counter stimulus and the counter response
   modport master (
      output enable, D, mode, Q, rco, load
   );

   // the checker only ever observes
   modport slave (
      input enable, D, mode, Q, rco, load
   );
endinterface

// File: rtl/counter_checker_model.sv
// rtl/counter_checker_model.sv - registered shadow of the 4-mode counter
module counter_model #(
   parameter int WIDTH = counter_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] exp_q,
   output logic             exp_rco,
   output logic             exp_load
);
   import counter_pkg::*;

   logic [WIDTH-1:0] exp_q_q, exp_q_d;
   logic             exp_rco_q, exp_rco_d;
   logic             exp_load_q, exp_load_d;

   // next count and the wrap/load flags the counter shows one cycle later
   always_comb begin
      exp_q_d    = exp_q_q;
      exp_rco_d  = 1'b0;
      exp_load_d = 1'b0;
      if (enable) begin
         unique case (mode)
            MODE_UP: begin
               exp_q_d   = exp_q_q + 1'b1;
               exp_rco_d = (exp_q_q == '1);
            end
            MODE_DN: begin
               exp_q_d   = exp_q_q - 1'b1;
               exp_rco_d = (exp_q_q == '0);
            end
            MODE_DN3: begin
               exp_q_d   = exp_q_q - WIDTH'(3);
               exp_rco_d = (exp_q_q < WIDTH'(3));
            end
            default: begin
               exp_q_d    = d;
               exp_load_d = 1'b1;
            end
         endcase
      end
   end

   // shadow registers, reset to the counter's own reset state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q_q    <= '0;
         exp_rco_q  <= 1'b0;
         exp_load_q <= 1'b0;
      end else begin
         exp_q_q    <= exp_q_d;
         exp_rco_q  <= exp_rco_d;
         exp_load_q <= exp_load_d;
      end
   end

   assign exp_q    = exp_q_q;
   assign exp_rco  = exp_rco_q;
   assign exp_load = exp_load_q;

endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - compares a counter against its shadow model and captures the first failure
module counter_checker #(
   parameter int WIDTH = counter_pkg::WIDTH,
   parameter int ERR_W = 8,
   parameter int CYC_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   counter_if.slave           bus,
   output logic               mismatch,
   output logic               err,
   output logic [ERR_W-1:0]   err_count,
   output logic [CYC_W-1:0]   first_cyc,
   output logic [WIDTH+1:0]   first_exp,
   output logic [WIDTH+1:0]   first_act
);
   import counter_pkg::*;

   logic [WIDTH-1:0] exp_q;
   logic             exp_rco;
   logic             exp_load;

   counter_model #(.WIDTH(WIDTH)) u_model (
      .clk      (clk),
      .reset    (reset),
      .enable   (bus.enable),
      .d        (bus.D),
      .mode     (bus.mode),
      .exp_q    (exp_q),
      .exp_rco  (exp_rco),
      .exp_load (exp_load)
   );

   chk_state_t       state_q;
   logic             mismatch_q;
   logic             err_q;
   logic [ERR_W-1:0] err_count_q;
   logic [CYC_W-1:0] first_cyc_q;
   logic [WIDTH+1:0] first_exp_q;
   logic [WIDTH+1:0] first_act_q;
   logic [CYC_W-1:0] cyc_q, cyc_d;

   logic [WIDTH+1:0] act_vec;
   logic [WIDTH+1:0] exp_vec;
   logic             diff;
   logic [ERR_W-1:0] err_count_inc;

   // sample vs shadow as held before the edge, plus the saturating count step
   always_comb begin
      act_vec       = {bus.Q, bus.rco, bus.load};
      exp_vec       = {exp_q, exp_rco, exp_load};
      diff          = (act_vec != exp_vec);
      err_count_inc = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
      cyc_d         = cyc_q + 1'b1;
   end

   // free-running cycle stamp, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cyc_q <= '0;
      else        cyc_q <= cyc_d;
   end

   // SYNC skips the first edge while the shadow aligns; CHECK captures the first failure; FAIL only counts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SYNC;
         mismatch_q  <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         first_cyc_q <= '0;
         first_exp_q <= '0;
         first_act_q <= '0;
      end else begin
         mismatch_q <= 1'b0;
         unique case (state_q)
            SYNC: state_q <= CHECK;
            CHECK: begin
               if (diff) begin
                  mismatch_q  <= 1'b1;
                  err_count_q <= err_count_inc;
                  err_q       <= 1'b1;
                  first_cyc_q <= cyc_q;
                  first_exp_q <= exp_vec;
                  first_act_q <= act_vec;
                  state_q     <= FAIL;
               end
            end
            FAIL: begin
               if (diff) begin
                  mismatch_q  <= 1'b1;
                  err_count_q <= err_count_inc;
               end
            end
            default: state_q <= SYNC;
         endcase
      end
   end

   assign mismatch  = mismatch_q;
   assign err       = err_q;
   assign err_count = err_count_q;
   assign first_cyc = first_cyc_q;
   assign first_exp = first_exp_q;
   assign first_act = first_act_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - directed/random bench for counter_checker with a behavioural reference
module tb_counter_checker;
   import counter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mismatch;
   logic        err;
   logic [7:0]  err_count;
   logic [15:0] first_cyc;
   logic [5:0]  first_exp;
   logic [5:0]  first_act;

   counter_if #(.WIDTH(4)) cif ();

   counter_checker #(.WIDTH(4), .ERR_W(8), .CYC_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (cif),
      .mismatch  (mismatch),
      .err       (err),
      .err_count (err_count),
      .first_cyc (first_cyc),
      .first_exp (first_exp),
      .first_act (first_act)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference state: a correct counter plus the checker's bookkeeping
   int       m_q;
   bit       m_rco, m_load;
   bit       m_sync, m_err, m_mm;
   int       m_cnt, m_cyc, m_fcyc;
   logic [5:0] m_fexp, m_fact;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q = 0; m_rco = 0; m_load = 0;
      m_sync = 1; m_err = 0; m_mm = 0;
      m_cnt = 0; m_cyc = 0; m_fcyc = 0;
      m_fexp = '0; m_fact = '0;
   endtask

   // entered at a negedge; asserts reset away from any rising edge and checks the clear is immediate
   task automatic apply_reset();
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_mismatch", mismatch, 0);
      check("rst_err", err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_first_cyc", first_cyc, 0);
      check("rst_first_exp", first_exp, 0);
      check("rst_first_act", first_act, 0);
      check("rst_exp_vec", {dut.exp_q, dut.exp_rco, dut.exp_load}, 0);
      check("rst_state", dut.state_q, SYNC);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // one clock of stimulus; mask corrupts the presented {Q,rco,load}
   task automatic step(input bit en, input logic [3:0] d, input logic [1:0] md, input logic [5:0] mask);
      logic [5:0] ev, pv;
      int nq;
      cif.enable = en;
      cif.D      = d;
      cif.mode   = md;
      ev = {4'(m_q), m_rco, m_load};
      pv = ev ^ mask;
      {cif.Q, cif.rco, cif.load} = pv;
      @(posedge clk);
      m_mm = 0;
      if (!m_sync && (pv != ev)) begin
         m_mm = 1;
         if (m_cnt < 255) m_cnt++;
         if (!m_err) begin
            m_err = 1; m_fcyc = m_cyc; m_fexp = ev; m_fact = pv;
         end
      end
      m_sync = 0;
      m_cyc  = (m_cyc + 1) % 65536;
      if (en) begin
         case (md)
            2'd0:    nq = m_q + 1;
            2'd1:    nq = m_q - 1;
            2'd2:    nq = m_q - 3;
            default: nq = int'(d);
         endcase
         m_rco  = (md != 2'd3) && (nq < 0 || nq > 15);
         m_load = (md == 2'd3);
         m_q    = (nq + 16) % 16;
      end else begin
         m_rco = 0; m_load = 0;
      end
      #1;
      check("mismatch", mismatch, m_mm);
      check("err", err, m_err);
      check("err_count", err_count, m_cnt);
      check("first_cyc", first_cyc, m_fcyc);
      check("first_exp", first_exp, m_fexp);
      check("first_act", first_act, m_fact);
      check("shadow", {dut.exp_q, dut.exp_rco, dut.exp_load}, {4'(m_q), m_rco, m_load});
      @(negedge clk);
   endtask

   int rco_hits;
   int dn_q [3] = '{15, 12, 9};

   initial begin
      cif.enable = 0; cif.D = 0; cif.mode = 0;
      cif.Q = 0; cif.rco = 0; cif.load = 0;

      apply_reset();

      // 20 up-counts from reset: wraps once
      rco_hits = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 4'($urandom_range(0, 15)), MODE_UP, 6'd0);
         if (dut.exp_rco) rco_hits++;
      end
      check("up_rco_once", rco_hits, 1);
      check("up_final_q", dut.exp_q, 4);
      check("up_no_err", err, 0);

      // load 2 then count down by 3 through the wrap
      step(1, 4'd2, MODE_LD, 6'd0);
      check("ld_q", dut.exp_q, 2);
      check("ld_load", dut.exp_load, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 4'($urandom_range(0, 15)), MODE_DN3, 6'd0);
         check("dn3_q", dut.exp_q, dn_q[i]);
         check("dn3_rco", dut.exp_rco, (i == 0) ? 1 : 0);
         check("dn3_load", dut.exp_load, 0);
      end

      // random clean traffic
      for (int i = 0; i < 40; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'd0);
      check("clean_err", err, 0);

      // single fault: present 5 while 6 is expected
      apply_reset();
      for (int i = 0; i < 6; i++) step(1, 4'd0, MODE_UP, 6'd0);
      step(1, 4'd0, MODE_UP, 6'b001100);
      check("fault_first_exp", first_exp, 6'b011000);
      check("fault_first_act", first_act, 6'b010100);
      check("fault_first_cyc", first_cyc, 6);
      for (int i = 0; i < 5; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'd0);

      // persistent fault drives the count into saturation
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              6'($urandom_range(1, 63)));
      check("sat_count", err_count, 255);

      // asynchronous reset while in FAIL, then a clean run
      apply_reset();
      for (int i = 0; i < 30; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'd0);
      check("post_rst_err", err, 0);

      // hold at 7 with enable low
      apply_reset();
      for (int i = 0; i < 7; i++) step(1, 4'd0, MODE_UP, 6'd0);
      for (int i = 0; i < 5; i++) begin
         step(0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'd0);
         check("hold_q", dut.exp_q, 7);
         check("hold_flags", {dut.exp_rco, dut.exp_load}, 0);
      end
      check("hold_no_err", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
